// File: rtl/logic_op_pipe.sv
// rtl/logic_op_pipe.sv - per-channel bitwise op pipe with XOR-accumulate, sticky error, output FIFO
module logic_op_pipe #(
    parameter int W     = 1,
    parameter int CH    = 1,
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pi_valid,
    output logic               po_ready,
    input  logic [2:0]         pi_op,
    input  logic [CH*W-1:0]    pi_a,
    input  logic [CH*W-1:0]    pi_b,
    output logic               po_valid,
    input  logic               pi_ready,
    output logic [CH*W-1:0]    po_c,
    output logic               po_err,
    output logic [CNT_W-1:0]   po_cnt,
    input  logic               pi_clr
);
    localparam int N  = CH * W;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0]      OCC_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0]      OCC_ONE  = (AW + 1)'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [N-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [AW:0]      r_occ;
    logic [N-1:0]     r_c;
    logic [N-1:0]     r_acc;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic [AW-1:0]    w_rd_nx;
    logic [N-1:0]     w_acc_eff;
    logic [N-1:0]     w_res;

    assign w_full   = (r_occ == OCC_FULL);
    assign po_ready = !w_full;
    assign po_valid = (r_occ != '0);
    assign w_push   = pi_valid && !w_full;
    assign w_pop    = po_valid && pi_ready;
    assign w_rd_nx  = r_rd + 1'b1;
    assign po_c     = r_c;
    assign po_err   = r_err;
    assign po_cnt   = r_cnt;

    // A clear in the same cycle makes an accumulate see a zeroed accumulator.
    assign w_acc_eff = pi_clr ? '0 : r_acc;

    always_comb begin
        w_res = '0;
        case (pi_op)
            3'd0:    w_res = pi_a & pi_b;
            3'd1:    w_res = pi_a | pi_b;
            3'd2:    w_res = pi_a ^ pi_b;
            3'd3:    w_res = ~(pi_a ^ pi_b);
            3'd4:    w_res = ~(pi_a & pi_b);
            3'd5:    w_res = ~(pi_a | pi_b);
            3'd6:    w_res = w_acc_eff ^ pi_a ^ pi_b;
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr  <= '0;
            r_rd  <= '0;
            r_occ <= '0;
            r_c   <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr] <= w_res;
                r_wr        <= r_wr + 1'b1;
            end
            if (w_pop) r_rd <= w_rd_nx;
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + 1'b1;
                2'b01:   r_occ <= r_occ - 1'b1;
                default: r_occ <= r_occ;
            endcase
            // r_c mirrors the FIFO head and holds its last value once drained.
            if (w_pop) begin
                if (r_occ > OCC_ONE) r_c <= r_mem[w_rd_nx];
                else if (w_push)     r_c <= w_res;
            end else if (!po_valid && w_push) begin
                r_c <= w_res;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (pi_clr) begin
            r_acc <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else if (w_push) begin
            if (pi_op == 3'd6) r_acc <= w_res;
            if (pi_op == 3'd7) r_err <= 1'b1;
            if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_logic_op_pipe.sv
// tb/tb_logic_op_pipe.sv - directed bench for logic_op_pipe (CH=4, W=1, DEPTH=2, CNT_W=3)
module tb_logic_op_pipe;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pi_valid = 1'b0;
    logic       po_ready;
    logic [2:0] pi_op = 3'd0;
    logic [3:0] pi_a = 4'd0;
    logic [3:0] pi_b = 4'd0;
    logic       po_valid;
    logic       pi_ready = 1'b0;
    logic [3:0] po_c;
    logic       po_err;
    logic [2:0] po_cnt;
    logic       pi_clr = 1'b0;

    int checks = 0;
    int errors = 0;

    logic_op_pipe #(.W(1), .CH(4), .DEPTH(2), .CNT_W(3)) dut (
        .clk(clk), .rst(rst),
        .pi_valid(pi_valid), .po_ready(po_ready), .pi_op(pi_op),
        .pi_a(pi_a), .pi_b(pi_b),
        .po_valid(po_valid), .pi_ready(pi_ready), .po_c(po_c),
        .po_err(po_err), .po_cnt(po_cnt), .pi_clr(pi_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        pi_valid = v;
        pi_op    = op;
        pi_a     = a;
        pi_b     = b;
    endtask

    initial begin
        // reset state
        #12;
        check("rst_valid", 32'(po_valid), 32'd0);
        check("rst_c",     32'(po_c),     32'h0);
        check("rst_ready", 32'(po_ready), 32'd1);
        check("rst_err",   32'(po_err),   32'd0);
        check("rst_cnt",   32'(po_cnt),   32'd0);
        rst = 1'b0;
        @(negedge clk);

        // ops 0..5 back-to-back with downstream always ready
        pi_ready = 1'b1;
        drive(1'b1, 3'd0, 4'b1100, 4'b1010); step();
        check("and_valid", 32'(po_valid), 32'd1);
        check("and",  32'(po_c), 32'b1000);
        drive(1'b1, 3'd1, 4'b1100, 4'b1010); step(); check("or",   32'(po_c), 32'b1110);
        drive(1'b1, 3'd2, 4'b1100, 4'b1010); step(); check("xor",  32'(po_c), 32'b0110);
        drive(1'b1, 3'd3, 4'b1100, 4'b1010); step(); check("xnor", 32'(po_c), 32'b1001);
        drive(1'b1, 3'd4, 4'b1100, 4'b1010); step(); check("nand", 32'(po_c), 32'b0111);
        drive(1'b1, 3'd5, 4'b1100, 4'b1010); step(); check("nor",  32'(po_c), 32'b0001);
        check("ops_ready", 32'(po_ready), 32'd1);
        drive(1'b0, 3'd0, 4'b0000, 4'b0000); step();
        check("drain_valid", 32'(po_valid), 32'd0);
        check("drain_hold",  32'(po_c),     32'b0001);
        check("cnt6",        32'(po_cnt),   32'd6);

        // XOR-accumulate: pairs (1,0),(1,1),(0,1) on every channel
        drive(1'b1, 3'd6, 4'b1111, 4'b0000); step(); check("acc1", 32'(po_c), 32'b1111);
        drive(1'b1, 3'd6, 4'b1111, 4'b1111); step(); check("acc2", 32'(po_c), 32'b1111);
        drive(1'b1, 3'd6, 4'b0000, 4'b1111); step(); check("acc3", 32'(po_c), 32'b0000);
        check("cnt_sat", 32'(po_cnt), 32'd7);
        drive(1'b1, 3'd6, 4'b0101, 4'b0000); step();
        check("acc_zero", 32'(po_c),   32'b0101);
        check("cnt_hold", 32'(po_cnt), 32'd7);

        // illegal op: zero result, sticky error, cleared by pi_clr
        drive(1'b1, 3'd7, 4'b1111, 4'b1111); step();
        check("ill_c",   32'(po_c),   32'h0);
        check("ill_err", 32'(po_err), 32'd1);
        drive(1'b0, 3'd0, 4'b0000, 4'b0000); step();
        check("err_sticky", 32'(po_err), 32'd1);
        pi_clr = 1'b1; step(); pi_clr = 1'b0;
        check("clr_err", 32'(po_err), 32'd0);
        check("clr_cnt", 32'(po_cnt), 32'd0);

        // pi_clr concurrent with accepts
        drive(1'b1, 3'd6, 4'b1000, 4'b0000); step();
        check("acc_load", 32'(po_c),   32'b1000);
        check("cnt1",     32'(po_cnt), 32'd1);
        pi_clr = 1'b1;
        drive(1'b1, 3'd6, 4'b0011, 4'b0101); step();
        check("clr_acc_res", 32'(po_c),   32'b0110);
        check("clr_acc_cnt", 32'(po_cnt), 32'd0);
        pi_clr = 1'b0;
        drive(1'b1, 3'd6, 4'b0000, 4'b0000); step();
        check("acc_after_clr", 32'(po_c),   32'b0000);
        check("cnt_after_clr", 32'(po_cnt), 32'd1);
        pi_clr = 1'b1;
        drive(1'b1, 3'd7, 4'b1111, 4'b1111); step();
        pi_clr = 1'b0;
        check("clr_ill_err",   32'(po_err),   32'd0);
        check("clr_ill_cnt",   32'(po_cnt),   32'd0);
        check("clr_ill_valid", 32'(po_valid), 32'd1);
        drive(1'b0, 3'd0, 4'b0000, 4'b0000); step();
        check("empty_again", 32'(po_valid), 32'd0);

        // backpressure, full FIFO, held third request, pointer wrap
        pi_ready = 1'b0;
        drive(1'b1, 3'd0, 4'b1111, 4'b0001); step();
        check("bp1_valid", 32'(po_valid), 32'd1);
        check("bp1_c",     32'(po_c),     32'b0001);
        check("bp1_ready", 32'(po_ready), 32'd1);
        drive(1'b1, 3'd1, 4'b0010, 4'b0100); step();
        check("bp2_ready", 32'(po_ready), 32'd0);
        check("bp2_c",     32'(po_c),     32'b0001);
        drive(1'b1, 3'd2, 4'b1111, 4'b0000); step();
        check("bp3_ready", 32'(po_ready), 32'd0);
        check("bp3_c",     32'(po_c),     32'b0001);
        check("bp3_cnt",   32'(po_cnt),   32'd2);
        pi_ready = 1'b1; step();
        check("pop1_c",     32'(po_c),     32'b0110);
        check("pop1_ready", 32'(po_ready), 32'd1);
        step();
        check("pop2_c",   32'(po_c),   32'b1111);
        check("pop2_cnt", 32'(po_cnt), 32'd3);
        drive(1'b0, 3'd0, 4'b0000, 4'b0000); step();
        check("pop3_valid", 32'(po_valid), 32'd0);
        check("pop3_hold",  32'(po_c),     32'b1111);

        // async reset with two entries queued and a request pending
        pi_ready = 1'b0;
        drive(1'b1, 3'd1, 4'b1010, 4'b0000); step();
        drive(1'b1, 3'd1, 4'b0101, 4'b0000); step();
        drive(1'b1, 3'd1, 4'b0011, 4'b0000);
        check("pre_rst_full", 32'(po_ready), 32'd0);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 32'(po_valid), 32'd0);
        check("arst_c",     32'(po_c),     32'h0);
        check("arst_ready", 32'(po_ready), 32'd1);
        check("arst_cnt",   32'(po_cnt),   32'd0);
        drive(1'b0, 3'd0, 4'b0000, 4'b0000);
        @(negedge clk);
        rst = 1'b0;
        pi_ready = 1'b1;
        step();
        check("post_rst_valid", 32'(po_valid), 32'd0);
        drive(1'b1, 3'd2, 4'b1100, 4'b0000); step();
        check("post_rst_c", 32'(po_c), 32'b1100);
        drive(1'b0, 3'd0, 4'b0000, 4'b0000); step();
        check("post_rst_empty", 32'(po_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
